// File: rtl/fp_pkg.sv
// Shared IEEE-754 definitions for the FP arithmetic unit (adder, multiplier, divider).
package fp_pkg;

  localparam int unsigned FP_EXP_W        = 8;
  localparam int unsigned FP_MAN_W        = 23;
  localparam int unsigned FP_BIAS         = (1 << (FP_EXP_W - 1)) - 1;
  localparam logic [31:0] FP_CANON_NAN_SP = 32'h7FC0_0000;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [1:0] {FP_ZERO, FP_INF, FP_NAN, FP_NORMAL} fp_class_e;

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} fp_div_state_e;

  // Denormals classify as zero: the unit flushes them on input.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    fp_class_e c;
    if (exp_zero)      c = FP_ZERO;
    else if (exp_ones) c = frac_zero ? FP_INF : FP_NAN;
    else               c = FP_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fp_mantissa_divider.sv
// Restoring radix-2 mantissa divider: one quotient bit per clock, MAN_W+3 bits per operation.
module fp_mantissa_divider #(
  parameter int unsigned MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W+1:0] dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             last_c,
  output logic [MAN_W+2:0] quotient,
  output logic             sticky
);

  localparam int unsigned QW = MAN_W + 3;
  localparam int unsigned RW = MAN_W + 2;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [RW-1:0]  rem_q;
  logic [MAN_W:0] dsr_q;
  logic [QW-1:0]  quo_q;
  logic [CW-1:0]  cnt_q;

  logic [RW-1:0]  rem_cur;
  logic [RW-1:0]  rem_sel;
  logic [MAN_W:0] dsr_cur;
  logic [RW:0]    diff;
  logic           bit_c;
  logic           step;

  // The start cycle already produces the first quotient bit from the incoming operands.
  always_comb begin
    rem_cur = start ? dividend : rem_q;
    dsr_cur = start ? divisor : dsr_q;
    diff    = {1'b0, rem_cur} - {2'b00, dsr_cur};
    bit_c   = ~diff[RW];
    rem_sel = bit_c ? diff[RW-1:0] : rem_cur;
    step    = start | ((cnt_q != '0) & (cnt_q < CW'(QW)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= RW'({rem_sel, 1'b0});
      quo_q <= start ? QW'(bit_c) : {quo_q[QW-2:0], bit_c};
      cnt_q <= start ? CW'(1) : cnt_q + CW'(1);
      if (start) dsr_q <= divisor;
    end
  end

  assign last_c   = (cnt_q == CW'(QW - 1));
  assign quotient = quo_q;
  assign sticky   = |rem_q;

endmodule

// File: rtl/floating_point_divider_sp.sv
// Iterative IEEE-754 divider (i_A / i_B): FSM, unpack, exponent path, rounding and result registers.
module floating_point_divider_sp
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic                   i_clk,
  input  logic                   i_RESET,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_A,
  input  logic [EXP_W+MAN_W:0]   i_B,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [EXP_W+MAN_W:0]   o_Q,
  output logic [4:0]             o_flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned QW   = MAN_W + 3;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] NAN_Q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  fp_div_state_e state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sign_q, sign_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [W-1:0]  q_d;
  fp_flags_t     flags_d;
  logic          valid_d, ready_d;

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  fa, fb;
  fp_class_e         cls_a, cls_b;
  logic [MAN_W:0]    ma, mb;
  logic              a_lt_b, sign_c;
  logic [MAN_W+1:0]  dividend_c;
  logic [EW-1:0]     exp_raw, exp_c;

  logic              spec_c;
  logic [W-1:0]      spec_q_c;
  fp_flags_t         spec_flags_c;

  logic              start_c, last_c, sticky_c;
  logic [QW-1:0]     quo_c;

  logic              round_up, inexact_c;
  logic [MAN_W+1:0]  mant_r;
  logic [MAN_W-1:0]  frac_r;
  logic [EW-1:0]     exp_r;
  logic [W-1:0]      rnd_q_c;
  fp_flags_t         rnd_flags_c;

  // Operand unpack, exponent difference and pre-normalisation so the quotient lands in [1,2).
  always_comb begin
    sa         = a_q[W-1];
    sb         = b_q[W-1];
    ea         = a_q[W-2:MAN_W];
    eb         = b_q[W-2:MAN_W];
    fa         = a_q[MAN_W-1:0];
    fb         = b_q[MAN_W-1:0];
    cls_a      = fp_classify(ea == '0, &ea, fa == '0);
    cls_b      = fp_classify(eb == '0, &eb, fb == '0);
    sign_c     = sa ^ sb;
    ma         = {1'b1, fa};
    mb         = {1'b1, fb};
    a_lt_b     = ma < mb;
    dividend_c = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
    exp_raw    = EW'(ea) - EW'(eb) + EW'(BIAS);
    exp_c      = a_lt_b ? exp_raw - EW'(1) : exp_raw;
  end

  // Special operands, in priority order.
  always_comb begin
    spec_c       = 1'b1;
    spec_q_c     = {sign_c, {(W-1){1'b0}}};
    spec_flags_c = '0;
    if (cls_a == FP_NAN || cls_b == FP_NAN || (cls_a == FP_ZERO && cls_b == FP_ZERO) ||
        (cls_a == FP_INF && cls_b == FP_INF)) begin
      spec_q_c             = NAN_Q;
      spec_flags_c.invalid = 1'b1;
    end else if (cls_b == FP_ZERO && cls_a != FP_INF) begin
      spec_q_c                 = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags_c.div_by_zero = 1'b1;
    end else if (cls_a == FP_INF) begin
      spec_q_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_b == FP_INF || cls_a == FP_ZERO) begin
      spec_q_c = {sign_c, {(W-1){1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  fp_mantissa_divider #(.MAN_W(MAN_W)) u_mant_div (
    .clk      (i_clk),
    .rst      (i_RESET),
    .start    (start_c),
    .dividend (dividend_c),
    .divisor  (mb),
    .last_c   (last_c),
    .quotient (quo_c),
    .sticky   (sticky_c)
  );

  // Round-to-nearest-even, renormalise on carry-out, then range check.
  always_comb begin
    inexact_c   = quo_c[1] | quo_c[0] | sticky_c;
    round_up    = quo_c[1] & (quo_c[0] | sticky_c | quo_c[2]);
    mant_r      = {1'b0, quo_c[QW-1:2]} + (MAN_W+2)'(round_up);
    frac_r      = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_r       = exp_q + EW'(mant_r[MAN_W+1]);
    rnd_q_c     = {sign_q, exp_r[EXP_W-1:0], frac_r};
    rnd_flags_c = '0;
    rnd_flags_c.inexact = inexact_c;
    if (!exp_r[EW-1] && exp_r >= EW'(EMAX)) begin
      rnd_q_c              = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags_c.overflow = 1'b1;
      rnd_flags_c.inexact  = 1'b1;
    end else if (exp_r[EW-1] || exp_r == '0) begin
      rnd_q_c               = {sign_q, {(W-1){1'b0}}};
      rnd_flags_c.underflow = 1'b1;
      rnd_flags_c.inexact   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    q_d     = o_Q;
    flags_d = fp_flags_t'(o_flags);
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_A;
          b_d     = i_B;
          state_d = PREP;
        end
      end
      PREP: begin
        sign_d = sign_c;
        exp_d  = exp_c;
        if (spec_c) begin
          q_d     = spec_q_c;
          flags_d = spec_flags_c;
          state_d = DONE;
        end else begin
          start_c = 1'b1;
          state_d = DIV;
        end
      end
      DIV:   if (last_c) state_d = ROUND;
      ROUND: begin
        q_d     = rnd_q_c;
        flags_d = rnd_flags_c;
        state_d = DONE;
      end
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      o_Q     <= '0;
      o_flags <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      o_Q     <= q_d;
      o_flags <= flags_d;
      o_valid <= valid_d;
      o_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_floating_point_divider_sp.sv
// Self-checking bench for floating_point_divider_sp: directed cases plus randomized traffic vs a reference model.
module tb_floating_point_divider_sp;

  logic        i_clk = 1'b0;
  logic        i_RESET;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_A, i_B;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_Q;
  logic [4:0]  o_flags;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [4:0]  f;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] sp_tab [0:7] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h3F80_0000};

  floating_point_divider_sp dut (
    .i_clk   (i_clk),
    .i_RESET (i_RESET),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_Q     (o_Q),
    .o_flags (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer quotient with remainder-based round-to-nearest-even.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [4:0] f, output bit spec);
    int unsigned ea, eb;
    longint unsigned ma, mb, num, qi, rem;
    int e;
    bit s, za, zb, ia, ib, na, nb, inx;
    ea = a[30:23];
    eb = b[30:23];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    s = a[31] ^ b[31];
    f = 5'b0;
    spec = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      q = 32'h7FC0_0000;
      f = 5'b10000;
    end else if (zb && !ia) begin
      q = {s, 8'hFF, 23'h0};
      f = 5'b01000;
    end else if (ia) begin
      q = {s, 8'hFF, 23'h0};
    end else if (ib || za) begin
      q = {s, 31'h0};
    end else begin
      spec = 1'b0;
      ma = 64'(a[22:0]) + 64'h80_0000;
      mb = 64'(b[22:0]) + 64'h80_0000;
      e = int'(ea) - int'(eb) + 127;
      if (ma < mb) begin
        num = ma << 24;
        e = e - 1;
      end else begin
        num = ma << 23;
      end
      qi = num / mb;
      rem = num % mb;
      inx = (rem != 0);
      if ((2 * rem > mb) || ((2 * rem == mb) && ((qi & 1) == 1))) qi = qi + 1;
      if (qi == 64'h100_0000) begin
        qi = qi >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        q = {s, 8'hFF, 23'h0};
        f = 5'b00101;
      end else if (e <= 0) begin
        q = {s, 31'h0};
        f = 5'b00011;
      end else begin
        q = {s, 8'(e), 23'(qi)};
        f = {4'b0, inx};
      end
    end
  endfunction

  // Scoreboard compare: every cycle a result is presented it must match the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_RESET && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        chk("q_model", o_Q, exp_q[0].q);
        chk("flags_model", 32'(o_flags), 32'(exp_q[0].f));
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit use_lit,
                        input logic [31:0] lit_q, input logic [4:0] lit_f,
                        input int abort_at, input bit pulse);
    logic [31:0] mq;
    logic [4:0]  mf;
    bit          sp;
    int          lat, n;
    model(a, b, mq, mf, sp);
    @(negedge i_clk);
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_valid = 1'b1;
    i_A = a;
    i_B = b;
    exp_q.push_back('{mq, mf});
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_A = $urandom;
    i_B = $urandom;
    lat = 1;
    while (!o_valid && lat < 60) begin
      if (pulse && lat == 8) begin
        i_valid = 1'b1;
        chk("ready_busy", 32'(o_ready), 32'd0);
      end
      if (abort_at != 0 && lat == abort_at) begin
        i_RESET = 1'b1;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        exp_q.delete();
        @(negedge i_clk);
        i_RESET = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), sp ? 32'd2 : 32'd28);
    if (use_lit) begin
      chk("q_literal", o_Q, lit_q);
      chk("flags_literal", 32'(o_flags), 32'(lit_f));
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int n;
    i_RESET = 1'b1;
    i_valid = 1'b0;
    i_A = '0;
    i_B = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_q", o_Q, 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    @(negedge i_clk);
    i_RESET = 1'b0;

    run_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 5'b00000, 0, 0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAB, 5'b00001, 0, 0);
    run_op(32'hBF80_0000, 32'h4080_0000, 1, 32'hBE80_0000, 5'b00000, 0, 0);
    run_op(32'h3F80_0000, 32'h0000_0000, 1, 32'h7F80_0000, 5'b01000, 0, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 1, 32'h7FC0_0000, 5'b10000, 0, 0);
    run_op(32'h7F80_0000, 32'h7F80_0000, 1, 32'h7FC0_0000, 5'b10000, 0, 0);
    run_op(32'h7F7F_FFFF, 32'h3F00_0000, 1, 32'h7F80_0000, 5'b00101, 0, 0);
    run_op(32'h0080_0000, 32'h4000_0000, 1, 32'h0000_0000, 5'b00011, 0, 0);

    // Result held while the consumer stalls.
    ready_mode = 2;
    run_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 5'b00000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("hold_q", o_Q, 32'h4040_0000);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_ready", 32'(o_ready), 32'd0);
    end
    ready_mode = 0;

    run_op(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAB, 5'b00001, 0, 1);

    run_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 5'b00000, 0, 0);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    chk("b2b_ready", 32'(o_ready), 32'd1);
    run_op(32'hBF80_0000, 32'h4080_0000, 1, 32'hBE80_0000, 5'b00000, 0, 0);

    run_op(32'h40C0_0000, 32'h4000_0000, 0, 32'h0, 5'b0, 11, 0);
    run_op(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 5'b00000, 0, 0);

    ready_mode = 1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          ra = sp_tab[$urandom_range(0, 7)];
          rb = sp_tab[$urandom_range(0, 7)];
        end
        2: begin
          ra = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
          rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        default: begin
          ra = {1'($urandom_range(0, 1)), 8'(97 + $urandom_range(0, 60)), 23'($urandom)};
          rb = {1'($urandom_range(0, 1)), 8'(97 + $urandom_range(0, 60)), 23'($urandom)};
        end
      endcase
      run_op(ra, rb, 0, 32'h0, 5'b0, 0, 0);
    end
    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
